// File: rtl/trax_move_parser.sv
// trax_move_parser: assembles referee ASCII lines into packed TRAX moves and a sticky colour
module trax_move_parser #(
  parameter int COL_W   = 10,
  parameter int ROW_W   = 10,
  parameter int MAX_DIG = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_valid,
  output logic [COL_W+ROW_W+1:0]   move_out,
  output logic                     end_receive,
  output logic                     color,
  output logic                     color_valid,
  output logic                     parse_error
);
  localparam int CW = COL_W + 6;
  localparam int RW = ROW_W + 4;
  localparam int DW = $clog2(MAX_DIG + 1);
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_CEND, S_COL, S_ROW, S_TEND, S_DROP} state_t;
  state_t                  state_q, state_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [DW-1:0]           dig_q, dig_d;
  logic                    lz_q, lz_d;
  logic                    at_q, at_d;
  logic [1:0]              tile_q, tile_d;
  logic                    pend_q, pend_d;
  logic [COL_W+ROW_W+1:0]  move_q, move_d;
  logic                    end_receive_q, end_receive_d;
  logic                    parse_error_q, parse_error_d;
  logic                    color_q, color_d;
  logic                    color_valid_q, color_valid_d;
  logic                    is_lf, is_cr, is_let, is_at, is_dig, is_tile, is_dash, is_wb;
  logic [1:0]              tile_v;
  logic [CW-1:0]           col_ext;
  logic [RW-1:0]           row_ext;
  logic                    col_ovf, row_ovf, row_full;
  assign is_lf    = rx_byte == 8'h0A;
  assign is_cr    = rx_byte == 8'h0D;
  assign is_at    = rx_byte == 8'h40;
  assign is_dash  = rx_byte == 8'h2D;
  assign is_wb    = rx_byte == 8'h57 || rx_byte == 8'h42;
  assign is_let   = rx_byte >= 8'h41 && rx_byte <= 8'h5A;
  assign is_dig   = rx_byte >= 8'h30 && rx_byte <= 8'h39;
  assign is_tile  = rx_byte == 8'h2B || rx_byte == 8'h2F || rx_byte == 8'h5C;
  assign tile_v   = rx_byte == 8'h2F ? 2'b01 : rx_byte == 8'h5C ? 2'b10 : 2'b00;
  // Letter value is the low five bits ('A'=1 .. 'Z'=26); overflow checked before truncation
  assign col_ext  = CW'(col_q) * CW'(26) + CW'(rx_byte[4:0]);
  assign row_ext  = RW'(row_q) * RW'(10) + RW'(rx_byte[3:0]);
  assign col_ovf  = |col_ext[CW-1:COL_W];
  assign row_ovf  = |row_ext[RW-1:ROW_W];
  assign row_full = dig_q == DW'(MAX_DIG);
  assign move_out    = move_q;
  assign end_receive = end_receive_q;
  assign color       = color_q;
  assign color_valid = color_valid_q;
  assign parse_error = parse_error_q;
  // Next-state and datapath decode for one accepted byte; CR and idle cycles leave everything held
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    dig_d         = dig_q;
    lz_d          = lz_q;
    at_d          = at_q;
    tile_d        = tile_q;
    pend_d        = pend_q;
    move_d        = move_q;
    end_receive_d = 1'b0;
    parse_error_d = 1'b0;
    color_d       = color_q;
    color_valid_d = color_valid_q;
    if (rx_valid && !is_cr) begin
      case (state_q)
        S_IDLE: begin
          state_d = is_dash ? S_CLR : (is_at || is_let) ? S_COL : is_lf ? S_IDLE : S_DROP;
          col_d   = is_let ? COL_W'(rx_byte[4:0]) : '0;
          at_d    = is_at;
        end
        S_CLR: begin
          state_d       = is_wb ? S_CEND : is_lf ? S_IDLE : S_DROP;
          pend_d        = is_wb ? rx_byte == 8'h42 : pend_q;
          parse_error_d = is_lf;
        end
        S_CEND: begin
          state_d       = is_lf ? S_IDLE : S_DROP;
          color_d       = is_lf ? pend_q : color_q;
          color_valid_d = color_valid_q | is_lf;
        end
        S_COL: begin
          if (is_let && !at_q && !col_ovf) begin
            col_d = col_ext[COL_W-1:0];
          end else if (is_dig) begin
            state_d = S_ROW;
            row_d   = ROW_W'(rx_byte[3:0]);
            dig_d   = DW'(1);
            lz_d    = rx_byte[3:0] == 4'd0;
          end else begin
            state_d       = is_lf ? S_IDLE : S_DROP;
            parse_error_d = is_lf;
          end
        end
        S_ROW: begin
          if (is_dig && !lz_q && !row_full && !row_ovf) begin
            row_d = row_ext[ROW_W-1:0];
            dig_d = dig_q + DW'(1);
          end else if (is_tile) begin
            state_d = S_TEND;
            tile_d  = tile_v;
          end else begin
            state_d       = is_lf ? S_IDLE : S_DROP;
            parse_error_d = is_lf;
          end
        end
        S_TEND: begin
          state_d       = is_lf ? S_IDLE : S_DROP;
          move_d        = is_lf ? {col_q, row_q, tile_q} : move_q;
          end_receive_d = is_lf;
        end
        S_DROP: begin
          state_d       = is_lf ? S_IDLE : S_DROP;
          parse_error_d = is_lf;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // All state and registered outputs, cleared by the synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      dig_q         <= '0;
      lz_q          <= 1'b0;
      at_q          <= 1'b0;
      tile_q        <= '0;
      pend_q        <= 1'b0;
      move_q        <= '0;
      end_receive_q <= 1'b0;
      parse_error_q <= 1'b0;
      color_q       <= 1'b0;
      color_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      dig_q         <= dig_d;
      lz_q          <= lz_d;
      at_q          <= at_d;
      tile_q        <= tile_d;
      pend_q        <= pend_d;
      move_q        <= move_d;
      end_receive_q <= end_receive_d;
      parse_error_q <= parse_error_d;
      color_q       <= color_d;
      color_valid_q <= color_valid_d;
    end
  end
endmodule

// File: tb/tb_trax_move_parser.sv
// tb_trax_move_parser: directed and randomized line checks against a line-level reference model
module tb_trax_move_parser;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [21:0] move_out;
  logic        end_receive, color, color_valid, parse_error;
  int          checks = 0, fails = 0;
  logic [7:0]  line_q[$];
  logic [21:0] exp_move = '0;
  logic        exp_color = 1'b0, exp_cv = 1'b0;
  int          exp_end_n = 0, exp_err_n = 0, obs_end_n = 0, obs_err_n = 0;
  logic        lf_end = 1'b0, lf_err = 1'b0, lf_exp_end = 1'b0, lf_exp_err = 1'b0;

  always #5 clock = ~clock;

  trax_move_parser dut (
    .clock(clock), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .move_out(move_out), .end_receive(end_receive), .color(color),
    .color_valid(color_valid), .parse_error(parse_error)
  );

  // Whole-line interpretation: 0 empty, 1 colour, 2 move, 3 error
  function automatic void eval_line(input logic [7:0] l[$], output int kind, output logic [21:0] mv, output logic c);
    int n, i, j, col, row;
    n = l.size(); kind = 3; mv = '0; c = 1'b0;
    if (n == 0) kind = 0;
    else if (l[0] == "-") begin
      if (n == 2 && (l[1] == "W" || l[1] == "B")) begin kind = 1; c = l[1] == "B"; end
    end else begin
      i = (l[0] == "@") ? 1 : 0; col = 0;
      while (i < n && l[0] != "@" && l[i] >= "A" && l[i] <= "Z") begin
        col = col * 26 + int'(l[i]) - 64;
        if (col > 1023) col = 2000;
        i++;
      end
      j = i; row = 0;
      while (j < n && l[j] >= "0" && l[j] <= "9") begin
        row = row * 10 + int'(l[j]) - 48;
        if (row > 1023) row = 2000;
        j++;
      end
      if (i > 0 && col <= 1023 && j - i >= 1 && j - i <= 4 && !(j - i > 1 && l[i] == "0") && row <= 1023 &&
          j + 1 == n && (l[j] == "+" || l[j] == "/" || l[j] == "\\")) begin
        kind = 2;
        mv = {10'(col), 10'(row), (l[j] == "/") ? 2'b01 : (l[j] == "\\") ? 2'b10 : 2'b00};
      end
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    obs_end_n += int'(end_receive);
    obs_err_n += int'(parse_error);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int kind;
    logic [21:0] mv;
    logic c;
    rx_byte = b;
    rx_valid = 1'b1;
    if (b == 8'h0A) begin
      eval_line(line_q, kind, mv, c);
      line_q.delete();
      lf_exp_end = kind == 2;
      lf_exp_err = kind == 3;
      exp_end_n += int'(lf_exp_end);
      exp_err_n += int'(lf_exp_err);
      if (kind == 2) exp_move = mv;
      if (kind == 1) begin exp_color = c; exp_cv = 1'b1; end
    end else if (b != 8'h0D) line_q.push_back(b);
    tick();
    if (b == 8'h0A) begin lf_end = end_receive; lf_err = parse_error; end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin rx_byte = 8'($urandom); tick(); end
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    line_q.delete();
    exp_move = '0; exp_color = 1'b0; exp_cv = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({move_out, end_receive, color, color_valid, parse_error} !== 26'h0) begin
      fails++;
      $display("FAIL reset_state: got move=%h end=%b col=%b cv=%b err=%b, want all zero", move_out, end_receive, color, color_valid, parse_error);
    end
  endtask

  task automatic test_colour();
    send_str("-B\n");
    checks++;
    if ({color, color_valid, lf_end, lf_err} !== 4'b1100) begin
      fails++;
      $display("FAIL colour_black: got col=%b cv=%b end=%b err=%b, want 1 1 0 0", color, color_valid, lf_end, lf_err);
    end
    idle(2);
    send_str("-W\r\n");
    checks++;
    if ({color, color_valid} !== 2'b01) begin
      fails++;
      $display("FAIL colour_repeat: got col=%b cv=%b, want 0 1", color, color_valid);
    end
  endtask

  task automatic test_zero_move();
    int e0;
    e0 = obs_end_n;
    send_str("@0+\n");
    checks++;
    if (lf_end !== 1'b1 || move_out !== 22'h0) begin
      fails++;
      $display("FAIL zero_move: got end=%b move=%h, want 1 000000", lf_end, move_out);
    end
    idle(3);
    checks++;
    if (obs_end_n - e0 !== 1) begin
      fails++;
      $display("FAIL zero_move_pulses: got %0d end pulses, want 1", obs_end_n - e0);
    end
  endtask

  task automatic test_move_cr();
    send_str("AB12/\r\n");
    checks++;
    if (lf_end !== 1'b1 || move_out !== {10'd28, 10'd12, 2'b01}) begin
      fails++;
      $display("FAIL move_cr: got end=%b move=%h, want 1 %h", lf_end, move_out, {10'd28, 10'd12, 2'b01});
    end
    idle(1);
  endtask

  task automatic test_errors();
    string errs[7] = '{"A1x\n", "A12345+\n", "A01+\n", "A1\n", "AMJ0+\n", "A1024+\n", "@A1+\n"};
    foreach (errs[k]) begin
      send_str(errs[k]);
      checks++;
      if (lf_err !== 1'b1 || lf_end !== 1'b0 || move_out !== {10'd28, 10'd12, 2'b01}) begin
        fails++;
        $display("FAIL error_line_%0d: got err=%b end=%b move=%h, want 1 0 %h", k, lf_err, lf_end, move_out, {10'd28, 10'd12, 2'b01});
      end
      idle(k % 2);
    end
  endtask

  task automatic test_boundary();
    send_str("AMI1023\\\n");
    checks++;
    if (lf_end !== 1'b1 || move_out !== {10'd1023, 10'd1023, 2'b10}) begin
      fails++;
      $display("FAIL boundary_max: got end=%b move=%h, want 1 %h", lf_end, move_out, {10'd1023, 10'd1023, 2'b10});
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int e0;
    e0 = obs_end_n;
    send_str("B7\\\n");
    checks++;
    if (lf_end !== 1'b1 || move_out !== {10'd2, 10'd7, 2'b10}) begin
      fails++;
      $display("FAIL b2b_first: got end=%b move=%h, want 1 %h", lf_end, move_out, {10'd2, 10'd7, 2'b10});
    end
    send_str("C3+\n");
    checks++;
    if (lf_end !== 1'b1 || move_out !== {10'd3, 10'd3, 2'b00}) begin
      fails++;
      $display("FAIL b2b_second: got end=%b move=%h, want 1 %h", lf_end, move_out, {10'd3, 10'd3, 2'b00});
    end
    idle(2);
    checks++;
    if (obs_end_n - e0 !== 2) begin
      fails++;
      $display("FAIL b2b_pulses: got %0d end pulses, want 2", obs_end_n - e0);
    end
  endtask

  task automatic test_reset_midline();
    int e0, r0;
    send_str("A1");
    do_reset();
    e0 = obs_end_n;
    r0 = obs_err_n;
    send_str("@0/\n");
    idle(2);
    checks++;
    if (obs_end_n - e0 !== 1 || obs_err_n - r0 !== 0 || move_out !== 22'h1) begin
      fails++;
      $display("FAIL reset_midline: got ends=%0d errs=%0d move=%h, want 1 0 000001", obs_end_n - e0, obs_err_n - r0, move_out);
    end
  endtask

  task automatic test_random();
    string alpha = "@AZMB09+/\\-Wx#";
    string tiles = "+/\\";
    logic [7:0] q[$];
    logic [7:0] d[$];
    int r, col, row, t;
    for (int n = 0; n < 200; n++) begin
      q.delete();
      d.delete();
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        col = $urandom_range(0, 1100);
        row = $urandom_range(0, 1100);
        if (col == 0) q.push_back("@");
        t = col;
        while (t > 0) begin q.push_front(8'(65 + (t - 1) % 26)); t = (t - 1) / 26; end
        if (row == 0) d.push_back("0");
        t = row;
        while (t > 0) begin d.push_front(8'(48 + t % 10)); t = t / 10; end
        if ($urandom_range(0, 7) == 0) d.push_front("0");
        foreach (d[k]) q.push_back(d[k]);
        q.push_back(tiles[$urandom_range(0, 2)]);
      end else if (r <= 7) begin
        q.push_back("-");
        q.push_back(r == 6 ? "W" : "B");
      end else if (r == 9) begin
        repeat ($urandom_range(1, 5)) q.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
      end
      if (q.size() > 0 && $urandom_range(0, 4) == 0)
        q[$urandom_range(0, q.size() - 1)] = alpha[$urandom_range(0, alpha.len() - 1)];
      foreach (q[k]) begin
        if ($urandom_range(0, 7) == 0) send_byte(8'h0D);
        send_byte(q[k]);
      end
      send_byte(8'h0A);
      checks++;
      if (lf_end !== lf_exp_end || lf_err !== lf_exp_err) begin
        fails++;
        $display("FAIL rand_pulse_%0d: got end=%b err=%b, want %b %b", n, lf_end, lf_err, lf_exp_end, lf_exp_err);
      end
      checks++;
      if (move_out !== exp_move) begin
        fails++;
        $display("FAIL rand_move_%0d: got %h, want %h", n, move_out, exp_move);
      end
      checks++;
      if ({color, color_valid} !== {exp_color, exp_cv}) begin
        fails++;
        $display("FAIL rand_colour_%0d: got %b%b, want %b%b", n, color, color_valid, exp_color, exp_cv);
      end
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_totals();
    idle(2);
    checks++;
    if (obs_end_n !== exp_end_n || obs_err_n !== exp_err_n) begin
      fails++;
      $display("FAIL pulse_totals: got end=%0d err=%0d, want %0d %0d", obs_end_n, obs_err_n, exp_end_n, exp_err_n);
    end
  endtask

  initial begin
    test_reset();
    test_colour();
    test_zero_move();
    test_move_cr();
    test_errors();
    test_boundary();
    test_back_to_back();
    test_reset_midline();
    test_random();
    test_totals();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
